// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: op encoding and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_SUB = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } serial_alu_state_t;

  // ADD and SUB propagate a carry; the logic ops do not.
  function automatic logic op_uses_carry(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit ALU cell shared by all ops; SUB is ADD with B inverted.
module alu_bit_cell
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    c,
  input  alu_op_t op,
  output logic    sum,
  output logic    carry
);

  logic bx;

  // Full adder for ADD/SUB, plain gates with no carry for AND/XOR.
  always_comb begin
    sum   = 1'b0;
    carry = 1'b0;
    bx    = b ^ (op == ALU_SUB);
    case (op)
      ALU_ADD, ALU_SUB: begin
        sum   = a ^ bx ^ c;
        carry = (a & bx) | (a & c) | (bx & c);
      end
      ALU_AND: sum = a & b;
      ALU_XOR: sum = a ^ b;
      default: sum = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one bit cell iterated WIDTH times with a registered carry,
// wrapped in a start/busy/done handshake.
// Optional feature macro: SERIAL_ALU_OVF_EN (signed overflow flag register).
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       aluctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             e,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  serial_alu_state_t state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  alu_op_t           op_q, op_d;
  logic              c_q, c_d, e_q, e_d, zero_q, zero_d, ovf_d;
  logic              cell_sum, cell_carry, last;
  logic [WIDTH-1:0]  res_shift;

  alu_bit_cell u_cell (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (c_q),
    .op    (op_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // New result bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  assign res_shift = (res_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
  assign last      = (cnt_q == CW'(WIDTH - 1));

  // Next-state, operand shifting and result capture on the final bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    zero_d  = zero_q;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_t'(aluctr);
          c_d     = op_uses_carry(alu_op_t'(aluctr)) ? cin : 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = cell_carry;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          d_d     = res_shift;
          e_d     = cell_carry;
          zero_d  = (res_shift == '0);
          // c_q is the carry into the MSB during the last bit.
          ovf_d   = op_uses_carry(op_q) & (c_q ^ cell_carry);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      c_q     <= 1'b0;
      d_q     <= '0;
      e_q     <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q;

  // Overflow flag updates only on the RUN->DONE edge, like the other flags.
  always_ff @(posedge clk) begin
    if (rst)                           ovf_q <= 1'b0;
    else if (state_q == RUN && last)   ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
  assign ovf        = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign e    = e_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu at WIDTH=8 and WIDTH=1.
module tb_serial_alu;

`ifdef SERIAL_ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, e8, zero8, ovf8;
  logic [1:0] ctl8;
  logic [7:0] a8, b8, d8;
  logic       start1, cin1, busy1, done1, e1, zero1, ovf1;
  logic [1:0] ctl1;
  logic [0:0] a1, b1, d1;

  int tests = 0;
  int fails = 0;
  int n;
  int dones;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .aluctr(ctl8), .busy(busy8), .done(done8), .d(d8), .e(e8),
    .zero(zero8), .ovf(ovf8)
  );

  serial_alu #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .aluctr(ctl1), .busy(busy1), .done(done1), .d(d1), .e(e1),
    .zero(zero1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op on the 8-bit DUT; n = edges after the start edge until done.
  task automatic op8(input logic [1:0] ctl, input logic [7:0] a, input logic [7:0] b,
                     input logic cin);
    ctl8 = ctl; a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 0; cin8 = 0; ctl8 = 0; a8 = 0; b8 = 0;
    start1 = 0; cin1 = 0; ctl1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_d",    d8,    0);
    chk("rst_e",    e8,    0);
    chk("rst_zero", zero8, 0);
    chk("rst_ovf",  ovf8,  0);
    rst = 1'b0;

    // ADD 0x7F + 0x01: signed overflow into the sign bit.
    ctl8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    chk("add_busy", busy8, 1);
    n = 0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("add_lat",  n,     8);
    chk("add_d",    d8,    8'h80);
    chk("add_e",    e8,    0);
    chk("add_zero", zero8, 0);
    chk("add_ovf",  ovf8,  OVF_ON);
    @(posedge clk); #1;
    chk("add_done_drop", done8, 0);

    op8(2'b10, 8'h05, 8'h05, 1'b1);
    chk("sub_eq_d",    d8,    8'h00);
    chk("sub_eq_e",    e8,    1);
    chk("sub_eq_zero", zero8, 1);
    chk("sub_eq_ovf",  ovf8,  0);

    op8(2'b10, 8'h03, 8'h05, 1'b1);
    chk("sub_neg_d",    d8,    8'hFE);
    chk("sub_neg_e",    e8,    0);
    chk("sub_neg_zero", zero8, 0);

    op8(2'b01, 8'hF0, 8'h3C, 1'b0);
    chk("and_d", d8, 8'h30);
    chk("and_e", e8, 0);

    op8(2'b11, 8'hFF, 8'h0F, 1'b1);
    chk("xor_d",   d8,   8'hF0);
    chk("xor_e",   e8,   0);
    chk("xor_ovf", ovf8, 0);

    // start re-pulsed mid-RUN with different operands must be ignored.
    ctl8 = 2'b00; a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (2) @(posedge clk);
    #1;
    ctl8 = 2'b01; a8 = 8'h00; b8 = 8'h00; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    n = 3;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("ign_lat", n,  8);
    chk("ign_d",   d8, 8'h46);

    // start held through DONE: second op begins on the DONE edge.
    ctl8 = 2'b10; a8 = 8'h10; b8 = 8'h01; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    n = 0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_lat1", n,  8);
    chk("b2b_d1",   d8, 8'h0F);
    chk("b2b_e1",   e8, 1);
    ctl8 = 2'b11; a8 = 8'hAA; b8 = 8'h55; cin8 = 0;
    @(posedge clk); #1;
    start8 = 0;
    chk("b2b_busy", busy8, 1);
    chk("b2b_done", done8, 0);
    chk("b2b_hold", d8,    8'h0F);
    n = 1;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_lat2", n,  9);
    chk("b2b_d2",   d8, 8'hFF);
    chk("b2b_e2",   e8, 0);

    // Reset in the 4th RUN cycle aborts the op and clears the outputs.
    ctl8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_d",    d8,    0);
    chk("abort_e",    e8,    0);
    chk("abort_zero", zero8, 0);
    chk("abort_ovf",  ovf8,  0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    chk("abort_no_done", dones, 0);

    // WIDTH=1: a single RUN cycle.
    ctl1 = 2'b00; a1 = 1'b1; b1 = 1'b1; cin1 = 1; start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    chk("w1_busy", busy1, 1);
    n = 0;
    while (!done1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("w1_lat", n,   1);
    chk("w1_d",   d1,  1);
    chk("w1_e",   e1,  1);
    chk("w1_ovf", ovf1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
